// File: rtl/tcm_mem_bank_if.sv
// Request/response bus between an axi_to_mem bridge (master) and a TCM bank (slave).
// Signal names are as seen from the bank side.
interface tcm_mem_bank_if #(
  parameter int AddrWidth = 32,
  parameter int DataWidth = 256
);
  logic                   mem_req_i;
  logic                   mem_gnt_o;
  logic [AddrWidth-1:0]   mem_addr_i;
  logic [DataWidth-1:0]   mem_wdata_i;
  logic [DataWidth/8-1:0] mem_strb_i;
  logic                   mem_we_i;
  logic                   mem_rvalid_o;
  logic [DataWidth-1:0]   mem_rdata_o;

  modport master (
    output mem_req_i, mem_addr_i, mem_wdata_i, mem_strb_i, mem_we_i,
    input  mem_gnt_o, mem_rvalid_o, mem_rdata_o
  );

  modport slave (
    input  mem_req_i, mem_addr_i, mem_wdata_i, mem_strb_i, mem_we_i,
    output mem_gnt_o, mem_rvalid_o, mem_rdata_o
  );
endinterface

// File: rtl/tcm_mem_bank.sv
// Single-port word-wide TCM bank: clear after reset, Latency-cycle responses, byte strobes.
// Optional random grant stalling when TCM_MEM_BANK_RAND_STALL_EN is defined.
module tcm_mem_bank #(
  parameter int AddrWidth    = 32,
  parameter int DataWidth    = 256,
  parameter int Depth        = 1024,
  parameter int Latency      = 1,
  parameter int ClearOnReset = 1
) (
  input  logic          clk,
  input  logic          reset,
  tcm_mem_bank_if.slave bus,
  output logic          init_done_o
);
  localparam int StrbW = DataWidth / 8;
  localparam int OffW  = $clog2(StrbW);
  localparam int IdxW  = (Depth > 1) ? $clog2(Depth) : 1;

  typedef enum logic [1:0] {ST_RESET, ST_CLEAR, ST_RUN} state_t;

  state_t               state;
  logic [IdxW-1:0]      clr_cnt;
  logic                 stall;
  logic                 fire;
  logic [IdxW-1:0]      widx;
  logic [DataWidth-1:0] mem [Depth];
  logic                 vld_p   [Latency];
  logic [DataWidth-1:0] rdata_p [Latency];

  // Upper address bits are dropped, so accesses wrap modulo the bank size.
  assign widx = bus.mem_addr_i[OffW +: IdxW];
  assign bus.mem_gnt_o = (state == ST_RUN) && !stall;
  assign fire = bus.mem_req_i && bus.mem_gnt_o;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_RESET;
      clr_cnt     <= '0;
      init_done_o <= 1'b0;
    end else begin
      unique case (state)
        ST_RESET: begin
          if (ClearOnReset != 0) begin
            state <= ST_CLEAR;
          end else begin
            state       <= ST_RUN;
            init_done_o <= 1'b1;
          end
        end
        ST_CLEAR: begin
          clr_cnt <= clr_cnt + IdxW'(1);
          if (clr_cnt == IdxW'(Depth - 1)) begin
            state       <= ST_RUN;
            init_done_o <= 1'b1;
          end
        end
        ST_RUN:  state <= ST_RUN;
        default: state <= ST_RESET;
      endcase
    end
  end

`ifdef TCM_MEM_BANK_RAND_STALL_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr <= 16'hACE1;
    end else if (state == ST_RUN) begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

  assign stall = (lfsr[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  // Array: the clear sweep owns the write port until RUN, so no grant can collide with it.
  always_ff @(posedge clk) begin
    if (state == ST_CLEAR) begin
      mem[clr_cnt] <= '0;
    end else if (fire && bus.mem_we_i) begin
      for (int b = 0; b < StrbW; b++) begin
        if (bus.mem_strb_i[b]) begin
          mem[widx][8*b +: 8] <= bus.mem_wdata_i[8*b +: 8];
        end
      end
    end
  end

  // Stage 0 captures the word at the grant edge; later stages only move on valid,
  // so the last stage (the output) holds its value between responses.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < Latency; k++) begin
        vld_p[k]   <= 1'b0;
        rdata_p[k] <= '0;
      end
    end else begin
      vld_p[0] <= fire;
      if (fire) begin
        rdata_p[0] <= bus.mem_we_i ? '0 : mem[widx];
      end
      for (int k = 1; k < Latency; k++) begin
        vld_p[k] <= vld_p[k-1];
        if (vld_p[k-1]) begin
          rdata_p[k] <= rdata_p[k-1];
        end
      end
    end
  end

  assign bus.mem_rvalid_o = vld_p[Latency-1];
  assign bus.mem_rdata_o  = rdata_p[Latency-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      assert (Latency >= 1 && Latency <= 4)
        else $error("tcm_mem_bank: Latency %0d outside 1..4", Latency);
      assert (DataWidth >= 8 && (DataWidth & (DataWidth - 1)) == 0)
        else $error("tcm_mem_bank: DataWidth %0d not a power of two >= 8", DataWidth);
      assert (Depth >= 2 && (Depth & (Depth - 1)) == 0)
        else $error("tcm_mem_bank: Depth %0d not a power of two >= 2", Depth);
      assert (AddrWidth >= OffW + IdxW)
        else $error("tcm_mem_bank: AddrWidth %0d too narrow", AddrWidth);
      assert (ClearOnReset == 0 || ClearOnReset == 1)
        else $error("tcm_mem_bank: ClearOnReset %0d not 0/1", ClearOnReset);
      assert ($bits(bus.mem_wdata_i) == DataWidth)
        else $error("tcm_mem_bank: interface data width differs from DataWidth");
    end else begin
      assert (!$isunknown(bus.mem_req_i))
        else $error("tcm_mem_bank: mem_req_i is X");
      if (bus.mem_req_i) begin
        assert (!$isunknown({bus.mem_we_i, bus.mem_addr_i, bus.mem_strb_i}))
          else $error("tcm_mem_bank: request carries X");
      end
    end
  end
endmodule

// File: tb/tb_tcm_mem_bank.sv
// Self-checking bench for tcm_mem_bank: reset/clear, strobes, latency, wrap,
// mid-operation reset and a randomized run against an array reference model.
module tb_tcm_mem_bank;
  localparam int AW    = 32;
  localparam int DW    = 256;
  localparam int SW    = DW / 8;
  localparam int DEPTH = 16;
  localparam int LAT   = 3;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] strb;
  } op_t;

  typedef struct {
    int            cyc;
    logic [DW-1:0] data;
  } rsp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic init_done;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  logic [DW-1:0] model_mem [DEPTH];
  op_t  ops[$];
  rsp_t exp_q[$];
  rsp_t obs_q[$];

  tcm_mem_bank_if #(.AddrWidth(AW), .DataWidth(DW)) bus ();

  tcm_mem_bank #(
    .AddrWidth(AW), .DataWidth(DW), .Depth(DEPTH), .Latency(LAT), .ClearOnReset(1)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus), .init_done_o(init_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int widx_of(logic [AW-1:0] a);
    return int'((a / SW) % DEPTH);
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
  endfunction

  function automatic void model_write(logic [AW-1:0] a, logic [DW-1:0] d, logic [SW-1:0] s);
    int w;
    w = widx_of(a);
    for (int b = 0; b < SW; b++) if (s[b]) model_mem[w][8*b +: 8] = d[8*b +: 8];
  endfunction

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] w;
    for (int i = 0; i < DW / 32; i++) w[32*i +: 32] = $urandom;
    return w;
  endfunction

  // Counts cycles with gnt low after reset release; also counts stray rvalid pulses.
  task automatic wait_init(output int n, output int bad);
    n = 0;
    bad = 0;
    while (!bus.mem_gnt_o && n < 4 * DEPTH + 20) begin
      if (bus.mem_rvalid_o) bad++;
      n++;
      tick();
    end
  endtask

  // Drives the ops queue back to back, honouring grant; records expected and observed responses.
  task automatic run_ops(output int stalls);
    int idx;
    int guard;
    int w;
    logic [DW-1:0] e;
    idx = 0;
    guard = 0;
    stalls = 0;
    exp_q.delete();
    obs_q.delete();
    while ((idx < ops.size() || obs_q.size() < exp_q.size()) && guard < ops.size() * 8 + 100) begin
      if (bus.mem_rvalid_o) obs_q.push_back('{cyc, bus.mem_rdata_o});
      if (idx < ops.size()) begin
        bus.mem_req_i   = 1'b1;
        bus.mem_we_i    = ops[idx].we;
        bus.mem_addr_i  = ops[idx].addr;
        bus.mem_wdata_i = ops[idx].wdata;
        bus.mem_strb_i  = ops[idx].strb;
      end else begin
        bus.mem_req_i = 1'b0;
      end
      if (init_done && !bus.mem_gnt_o) stalls++;
      if (bus.mem_req_i && bus.mem_gnt_o) begin
        w = widx_of(ops[idx].addr);
        e = ops[idx].we ? '0 : model_mem[w];
        if (ops[idx].we) model_write(ops[idx].addr, ops[idx].wdata, ops[idx].strb);
        exp_q.push_back('{cyc, e});
        idx++;
      end
      tick();
      guard++;
    end
    bus.mem_req_i = 1'b0;
    repeat (LAT + 2) begin
      if (bus.mem_rvalid_o) obs_q.push_back('{cyc, bus.mem_rdata_o});
      tick();
    end
  endtask

  task automatic test_reset();
    int n, bad, st;
    bus.mem_req_i = 1'b0;
    reset = 1'b1;
    repeat (3) tick();
    checks++; if (bus.mem_gnt_o !== 1'b0) begin errors++; $display("FAIL rst_gnt got %b want 0", bus.mem_gnt_o); end
    checks++; if (bus.mem_rvalid_o !== 1'b0) begin errors++; $display("FAIL rst_rvalid got %b want 0", bus.mem_rvalid_o); end
    checks++; if (bus.mem_rdata_o !== '0) begin errors++; $display("FAIL rst_rdata got %h want 0", bus.mem_rdata_o); end
    checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL rst_init_done got %b want 0", init_done); end
    bus.mem_we_i = 1'b0;
    bus.mem_addr_i = 32'h1E0;
    bus.mem_req_i = 1'b1;
    reset = 1'b0;
    wait_init(n, bad);
    // One cycle in RESET after release, then one cycle per cleared word.
    checks++; if (n != DEPTH + 1) begin errors++; $display("FAIL holdoff_cycles got %0d want %0d", n, DEPTH + 1); end
    checks++; if (bad != 0) begin errors++; $display("FAIL holdoff_rvalid got %0d want 0", bad); end
    checks++; if (init_done !== 1'b1) begin errors++; $display("FAIL init_done got %b want 1", init_done); end
    model_clear();
    ops.delete();
    ops.push_back('{1'b0, 32'h1E0, '0, '0});
    run_ops(st);
    checks++; if (obs_q.size() != 1) begin errors++; $display("FAIL clr_read_count got %0d want 1", obs_q.size()); end
    if (obs_q.size() == 1) begin
      checks++; if (obs_q[0].data !== '0) begin errors++; $display("FAIL clr_read_data got %h want 0", obs_q[0].data); end
      checks++; if (obs_q[0].cyc - exp_q[0].cyc != LAT) begin errors++; $display("FAIL clr_read_lat got %0d want %0d", obs_q[0].cyc - exp_q[0].cyc, LAT); end
    end
  endtask

  task automatic test_strobe_write();
    int st;
    logic [DW-1:0] want;
    want = '0;
    want[31:0] = 32'hAAAA_AAAA;
    ops.delete();
    ops.push_back('{1'b1, 32'h20, {SW{8'hAA}}, SW'(32'h0000_000F)});
    ops.push_back('{1'b0, 32'h20, '0, '0});
    run_ops(st);
    checks++; if (obs_q.size() != 2) begin errors++; $display("FAIL strb_count got %0d want 2", obs_q.size()); end
    if (obs_q.size() == 2) begin
      checks++; if (obs_q[0].data !== '0) begin errors++; $display("FAIL strb_wr_rsp got %h want 0", obs_q[0].data); end
      checks++; if (obs_q[1].data !== want) begin errors++; $display("FAIL strb_rd_data got %h want %h", obs_q[1].data, want); end
      checks++; if (obs_q[1].cyc - obs_q[0].cyc != exp_q[1].cyc - exp_q[0].cyc) begin errors++; $display("FAIL strb_order got gap %0d want %0d", obs_q[1].cyc - obs_q[0].cyc, exp_q[1].cyc - exp_q[0].cyc); end
    end
  endtask

  task automatic test_latency();
    int st;
    ops.delete();
    for (int i = 0; i < 4; i++) ops.push_back('{1'b1, AW'(i * SW), DW'(i + 1), '1});
    for (int i = 0; i < 4; i++) ops.push_back('{1'b0, AW'(i * SW), '0, '0});
    run_ops(st);
    checks++; if (obs_q.size() != 8) begin errors++; $display("FAIL lat_count got %0d want 8", obs_q.size()); end
    if (obs_q.size() == 8) begin
      for (int i = 0; i < 4; i++) begin
        checks++; if (obs_q[4+i].data !== DW'(i + 1)) begin errors++; $display("FAIL lat_data[%0d] got %h want %0d", i, obs_q[4+i].data, i + 1); end
        checks++; if (obs_q[4+i].cyc - exp_q[4+i].cyc != LAT) begin errors++; $display("FAIL lat_cycles[%0d] got %0d want %0d", i, obs_q[4+i].cyc - exp_q[4+i].cyc, LAT); end
      end
    end
    checks++; if (bus.mem_rvalid_o !== 1'b0) begin errors++; $display("FAIL hold_rvalid got %b want 0", bus.mem_rvalid_o); end
    checks++; if (bus.mem_rdata_o !== DW'(4)) begin errors++; $display("FAIL hold_rdata got %h want 4", bus.mem_rdata_o); end
  endtask

  task automatic test_wrap();
    int st;
    logic [DW-1:0] d0, d1;
    d0 = rand_word();
    d1 = rand_word();
    ops.delete();
    ops.push_back('{1'b1, AW'(DEPTH * SW), d0, '1});
    ops.push_back('{1'b0, 32'h0, '0, '0});
    ops.push_back('{1'b1, 32'hABCD_0000 | AW'(3 * SW + 5), d1, '1});
    ops.push_back('{1'b0, AW'(3 * SW), '0, '0});
    run_ops(st);
    checks++; if (obs_q.size() != 4) begin errors++; $display("FAIL wrap_count got %0d want 4", obs_q.size()); end
    if (obs_q.size() == 4) begin
      checks++; if (obs_q[1].data !== d0) begin errors++; $display("FAIL wrap_word0 got %h want %h", obs_q[1].data, d0); end
      checks++; if (obs_q[3].data !== d1) begin errors++; $display("FAIL wrap_high_bits got %h want %h", obs_q[3].data, d1); end
    end
  endtask

  task automatic test_mid_reset();
    int st, g, guard, n, bad, stray;
    logic [DW-1:0] d;
    d = rand_word() | DW'(1);
    ops.delete();
    ops.push_back('{1'b1, AW'(7 * SW), d, '1});
    ops.push_back('{1'b0, AW'(7 * SW), '0, '0});
    run_ops(st);
    checks++; if (obs_q.size() != 2 || obs_q[obs_q.size()-1].data !== d) begin errors++; $display("FAIL pre_reset_read got %0d rsps want 2 with %h", obs_q.size(), d); end
    g = 0;
    guard = 0;
    bus.mem_we_i = 1'b0;
    bus.mem_req_i = 1'b1;
    while (g < 2 && guard < 50) begin
      bus.mem_addr_i = AW'((7 + g) * SW);
      if (bus.mem_gnt_o) g++;
      tick();
      guard++;
    end
    checks++; if (g != 2) begin errors++; $display("FAIL mid_grants got %0d want 2", g); end
    bus.mem_req_i = 1'b0;
    reset = 1'b1;
    tick();
    stray = 0;
    if (bus.mem_rvalid_o) stray++;
    tick();
    if (bus.mem_rvalid_o) stray++;
    checks++; if (bus.mem_gnt_o !== 1'b0) begin errors++; $display("FAIL mid_rst_gnt got %b want 0", bus.mem_gnt_o); end
    checks++; if (bus.mem_rdata_o !== '0) begin errors++; $display("FAIL mid_rst_rdata got %h want 0", bus.mem_rdata_o); end
    checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL mid_rst_init_done got %b want 0", init_done); end
    reset = 1'b0;
    wait_init(n, bad);
    checks++; if (stray + bad != 0) begin errors++; $display("FAIL mid_rst_rvalid got %0d pulses want 0", stray + bad); end
    checks++; if (n != DEPTH + 1) begin errors++; $display("FAIL mid_rst_reclear got %0d want %0d", n, DEPTH + 1); end
    model_clear();
    ops.delete();
    ops.push_back('{1'b0, AW'(7 * SW), '0, '0});
    run_ops(st);
    checks++; if (obs_q.size() != 1 || obs_q[0].data !== '0) begin errors++; $display("FAIL mid_rst_cleared got %0d rsps want 1 with 0", obs_q.size()); end
  endtask

  task automatic test_random();
    int st, bad_d, bad_l;
    op_t o;
    ops.delete();
    for (int i = 0; i < 1000; i++) begin
      o.we    = 1'($urandom_range(0, 1));
      o.addr  = AW'($urandom_range(0, DEPTH * 4 - 1) * SW + $urandom_range(0, SW - 1));
      o.wdata = rand_word();
      case ($urandom_range(0, 3))
        0:       o.strb = '0;
        1:       o.strb = '1;
        default: o.strb = SW'($urandom);
      endcase
      ops.push_back(o);
    end
    run_ops(st);
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    bad_d = 0;
    bad_l = 0;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i].data !== exp_q[i].data) begin
        errors++;
        $display("FAIL rand_data[%0d] got %h want %h", i, obs_q[i].data, exp_q[i].data);
      end
      checks++;
      if (obs_q[i].cyc - exp_q[i].cyc != LAT) begin
        errors++;
        $display("FAIL rand_lat[%0d] got %0d want %0d", i, obs_q[i].cyc - exp_q[i].cyc, LAT);
      end
    end
`ifdef TCM_MEM_BANK_RAND_STALL_EN
    checks++; if (st < 1) begin errors++; $display("FAIL rand_stalls got %0d want >=1", st); end
`else
    checks++; if (st != 0) begin errors++; $display("FAIL rand_stalls got %0d want 0", st); end
`endif
  endtask

  initial begin
    bus.mem_req_i   = 1'b0;
    bus.mem_we_i    = 1'b0;
    bus.mem_addr_i  = '0;
    bus.mem_wdata_i = '0;
    bus.mem_strb_i  = '0;
    test_reset();
    test_strobe_write();
    test_latency();
    test_wrap();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
